// File: rtl/cpu_pkg.sv
// Shared CPU definitions: one-hot ALU op codes, write-back bus destinations,
// and the write-back stage state encoding.
package cpu_pkg;

  localparam int CPU_OP_W = 13;

  localparam logic [CPU_OP_W-1:0] OP_AND  = 13'b0_0000_0000_0001;
  localparam logic [CPU_OP_W-1:0] OP_OR   = 13'b0_0000_0000_0010;
  localparam logic [CPU_OP_W-1:0] OP_ADD  = 13'b0_0000_0000_0100;
  localparam logic [CPU_OP_W-1:0] OP_SUB  = 13'b0_0000_0000_1000;
  localparam logic [CPU_OP_W-1:0] OP_MUL  = 13'b0_0000_0001_0000;
  localparam logic [CPU_OP_W-1:0] OP_DIV  = 13'b0_0000_0010_0000;
  localparam logic [CPU_OP_W-1:0] OP_SHR  = 13'b0_0000_0100_0000;
  localparam logic [CPU_OP_W-1:0] OP_SHRA = 13'b0_0000_1000_0000;
  localparam logic [CPU_OP_W-1:0] OP_SHL  = 13'b0_0001_0000_0000;
  localparam logic [CPU_OP_W-1:0] OP_ROR  = 13'b0_0010_0000_0000;
  localparam logic [CPU_OP_W-1:0] OP_ROL  = 13'b0_0100_0000_0000;
  localparam logic [CPU_OP_W-1:0] OP_NEG  = 13'b0_1000_0000_0000;
  localparam logic [CPU_OP_W-1:0] OP_NOT  = 13'b1_0000_0000_0000;

  localparam logic [1:0] DEST_ZLO = 2'b00;
  localparam logic [1:0] DEST_LO  = 2'b01;
  localparam logic [1:0] DEST_HI  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EMIT_LO = 2'b01,
    ST_EMIT_HI = 2'b10
  } wb_state_t;

endpackage

// File: rtl/z_writeback.sv
// ALU write-back stage: captures the 64-bit Z result and drains it onto the
// 32-bit bus (MUL/DIV as LO then HI). Optional zero/neg flags under WB_FLAGS_EN.
module z_writeback
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 13
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [OP_W-1:0]       alu_op,
  input  logic [2*DATA_W-1:0]   alu_result,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [DATA_W-1:0]     bus_data,
  output logic [1:0]            bus_dest,
  output logic [DATA_W-1:0]     hi_q,
  output logic [DATA_W-1:0]     lo_q,
  output logic                  carry_q,
  output logic                  op_err,
`ifdef WB_FLAGS_EN
  output logic                  zero_q,
  output logic                  neg_q,
`endif
  output logic                  busy
);

  wb_state_t             state;
  logic [2*DATA_W-1:0]   z_q;
  logic [OP_W-1:0]       op_q;
  logic                  wide_q;

  function automatic logic is_onehot(input logic [OP_W-1:0] op);
    return (op != '0) && ((op & (op - 1'b1)) == '0);
  endfunction

  // Illegal encodings never match MUL/DIV exactly, so they drain as narrow ops.
  function automatic logic is_wide(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  assign wide_q    = is_wide(op_q);
  assign alu_ready = (state == ST_IDLE);
  assign bus_valid = (state != ST_IDLE);
  assign busy      = bus_valid;

  always_comb begin
    bus_data = '0;
    bus_dest = DEST_ZLO;
    case (state)
      ST_EMIT_LO: begin
        bus_data = z_q[DATA_W-1:0];
        bus_dest = wide_q ? DEST_LO : DEST_ZLO;
      end
      ST_EMIT_HI: begin
        bus_data = z_q[2*DATA_W-1:DATA_W];
        bus_dest = DEST_HI;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= ST_IDLE;
      z_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      carry_q <= 1'b0;
      op_err  <= 1'b0;
`ifdef WB_FLAGS_EN
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      op_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (alu_valid) begin
            z_q    <= alu_result;
            op_q   <= alu_op;
            op_err <= !is_onehot(alu_op);
            state  <= ST_EMIT_LO;
            if (alu_op == OP_ADD) carry_q <= alu_result[DATA_W];
`ifdef WB_FLAGS_EN
            if (is_wide(alu_op)) begin
              zero_q <= (alu_result == '0);
              neg_q  <= alu_result[2*DATA_W-1];
            end else begin
              zero_q <= (alu_result[DATA_W-1:0] == '0);
              neg_q  <= alu_result[DATA_W-1];
            end
`endif
          end
        end
        ST_EMIT_LO: begin
          if (bus_ready) begin
            if (wide_q) begin
              lo_q  <= z_q[DATA_W-1:0];
              state <= ST_EMIT_HI;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_EMIT_HI: begin
          if (bus_ready) begin
            hi_q  <= z_q[2*DATA_W-1:DATA_W];
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
